reward_generator: RTL

REWARD_GENERATOR -- requirements
Module: reward_generator

---
 rtl/reward_generator_pkg.sv | 37 +++
 rtl/lfsr16.sv | 37 +++
 rtl/reward_generator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/reward_generator_pkg.sv
// -----------------------------------------------------------------------------
// reward_generator_pkg
// Shared snake-game definitions: playfield size, reward type codes, the reward
// generator state encoding and the latched reward record. The display stage
// imports the same package so both sides agree on grid bounds and type codes.
// -----------------------------------------------------------------------------
package reward_generator_pkg;

  localparam int unsigned GRID_W = 24;
  localparam int unsigned GRID_H = 18;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] RT_NONE    = 2'b00;
  localparam logic [1:0] RT_PROTECT = 2'b01;
  localparam logic [1:0] RT_GRADE   = 2'b10;
  localparam logic [1:0] RT_SLOW    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SHOW = 2'd2,
    ST_HIT  = 2'd3
  } rg_state_e;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] rtype;
  } reward_t;

  // Folds a 5-bit random value into 0..lim-1 with a single subtraction.
  // Valid for lim >= 16, which holds for both grid dimensions.
  function automatic logic [5:0] fold5(input logic [4:0] v, input logic [4:0] lim);
    return (v < lim) ? {1'b0, v} : {1'b0, v - lim};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
// Advances every clock. An all-zero state would lock up, so it reloads SEED.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset, loads SEED
//   lfsr_o out  current 16-bit register value
// -----------------------------------------------------------------------------
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = (lfsr_q == 16'd0) ? SEED : {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reward_generator.sv
// -----------------------------------------------------------------------------
// reward_generator
// Spawns a reward at a pseudo-random grid cell, keeps it visible for a number
// of snake steps, detects the head taking it and runs the protect/slow effect
// timers that a taken reward starts.
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   game_run       in   game in progress; low forces IDLE and clears effects
//   move_tick      in   one-cycle pulse per snake step
//   head_x/head_y  in   snake head column/row
//   enable_reward  out  reward visible (registered, high exactly in SHOW)
//   random_xpos    out  latched reward column 0..23
//   random_ypos    out  latched reward row 0..17
//   reward_type    out  01 protect, 10 grade, 11 slow
//   reward_hit     out  one-cycle pulse when the head takes the reward
//   score_bonus    out  one-cycle pulse on a grade hit
//   protect_active out  protect effect running
//   slow_active    out  slow effect running
// -----------------------------------------------------------------------------
module reward_generator
  import reward_generator_pkg::*;
#(
  parameter int unsigned SPAWN_DELAY  = 5,
  parameter int unsigned LIFETIME     = 8,
  parameter int unsigned EFFECT_TICKS = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_run,
  input  logic       move_tick,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  output logic       enable_reward,
  output logic [5:0] random_xpos,
  output logic [5:0] random_ypos,
  output logic [1:0] reward_type,
  output logic       reward_hit,
  output logic       score_bonus,
  output logic       protect_active,
  output logic       slow_active
);

  localparam logic [CNT_W-1:0] SPAWN_C  = CNT_W'(SPAWN_DELAY);
  localparam logic [CNT_W-1:0] LIFE_C   = CNT_W'(LIFETIME);
  localparam logic [CNT_W-1:0] EFFECT_C = CNT_W'(EFFECT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_ONE;
  endfunction

  rg_state_e        state_q, state_d;
  logic             enable_q;
  reward_t          pos_q, pos_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] life_q, life_d;
  logic [CNT_W-1:0] prot_q, prot_d;
  logic [CNT_W-1:0] slow_q, slow_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  reward_t     cand;
  logic        head_on_cand;
  logic        head_on_reward;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  // Upper LFSR bits are not needed for position or type.
  assign lfsr_unused = ^lfsr[15:12];

  // Spawn candidate from the current LFSR value. A candidate landing on the
  // head is shifted one column right (wrapping) so it never spawns already taken.
  always_comb begin
    cand.x       = fold5(lfsr[4:0], 5'(GRID_W));
    cand.y       = fold5(lfsr[9:5], 5'(GRID_H));
    cand.rtype   = (lfsr[11:10] == RT_NONE) ? RT_PROTECT : lfsr[11:10];
    head_on_cand = (cand.x == head_x) && (cand.y == head_y);
    if (head_on_cand) begin
      cand.x = (cand.x == 6'(GRID_W - 1)) ? 6'd0 : cand.x + 6'd1;
    end
  end

  assign head_on_reward = (head_x == pos_q.x) && (head_y == pos_q.y);

  // State register; enable is registered from the next state so it is high
  // exactly for the cycles spent in SHOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= (state_d == ST_SHOW);
    end
  end

  // Next-state logic. Dropping game_run wins over everything else.
  always_comb begin
    state_d = state_q;
    if (!game_run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (move_tick && (dly_q <= CNT_ONE)) begin
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          // A hit on the tick that would also expire the reward is still a hit.
          if (move_tick) begin
            if (head_on_reward) begin
              state_d = ST_HIT;
            end else if (life_q <= CNT_ONE) begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_HIT:  state_d = ST_WAIT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counter and latched-reward next state.
  always_comb begin
    dly_d  = dly_q;
    life_d = life_q;
    prot_d = prot_q;
    slow_d = slow_q;
    pos_d  = pos_q;

    if (move_tick) begin
      prot_d = sat_dec(prot_q);
      slow_d = sat_dec(slow_q);
      if (state_q == ST_WAIT) begin
        dly_d = sat_dec(dly_q);
      end
      if (state_q == ST_SHOW) begin
        life_d = sat_dec(life_q);
      end
    end

    if ((state_q != ST_WAIT) && (state_d == ST_WAIT)) begin
      dly_d = SPAWN_C;
    end

    if ((state_q == ST_WAIT) && (state_d == ST_SHOW)) begin
      pos_d  = cand;
      life_d = LIFE_C;
    end

    // A taken reward restarts its own effect timer; the other keeps counting.
    if ((state_q == ST_SHOW) && (state_d == ST_HIT)) begin
      if (pos_q.rtype == RT_PROTECT) begin
        prot_d = EFFECT_C;
      end
      if (pos_q.rtype == RT_SLOW) begin
        slow_d = EFFECT_C;
      end
    end

    if (!game_run) begin
      dly_d  = '0;
      life_d = '0;
      prot_d = '0;
      slow_d = '0;
      pos_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q  <= '0;
      life_q <= '0;
      prot_q <= '0;
      slow_q <= '0;
      pos_q  <= '0;
    end else begin
      dly_q  <= dly_d;
      life_q <= life_d;
      prot_q <= prot_d;
      slow_q <= slow_d;
      pos_q  <= pos_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    reward_hit  = 1'b0;
    score_bonus = 1'b0;
    if (state_q == ST_HIT) begin
      reward_hit  = 1'b1;
      score_bonus = (pos_q.rtype == RT_GRADE);
    end
  end

  assign enable_reward  = enable_q;
  assign random_xpos    = pos_q.x;
  assign random_ypos    = pos_q.y;
  assign reward_type    = pos_q.rtype;
  assign protect_active = (prot_q != '0);
  assign slow_active    = (slow_q != '0);

endmodule
